// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the multi-channel frequency counter:
// FSM state encoding, gate-shift width and the 7-segment decode table.
package freq_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GATE  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int GATE_SHIFT_W = 2;
  localparam int BCD_DIGITS   = 6;
  localparam int DD_MAX_BITS  = 20;
  localparam int SCAN_W       = 16;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

  // Double-dabble correction step: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [23:0] bcd_adjust(input logic [23:0] bcd);
    logic [23:0] r;
    r = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_edge_counter.sv
// One measurement channel: 2-flop synchronizer, rising-edge detector and a
// saturating edge counter with synchronous clear and count enable.
module freq_edge_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freq_in,
  input  logic             count_en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  // [0],[1] synchronize; [2] holds the previous synchronized level.
  logic [2:0] sync_q;
  logic       edge_det;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], freq_in};
  end

  assign edge_det = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (count_en && edge_det) begin
      if (&count) sat   <= 1'b1;
      else        count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/freq_counter_mc.sv
// Multi-channel gated frequency counter with optional 6-digit 7-segment
// display path, compiled in when FREQ_COUNTER_SEG_EN is defined.
module freq_counter_mc
  import freq_counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 50_000_000,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       freq_in,
  input  logic                    enable,
  input  logic                    single_shot,
  input  logic [GATE_SHIFT_W-1:0] gate_sel,
  input  logic [SEL_W-1:0]        ch_sel,
  output logic [CNT_W-1:0]        count_out,
  output logic                    count_valid,
  output logic [NUM_CH-1:0]       overflow,
  output logic                    busy,
  output logic [6:0]              segment_output,
  output logic [5:0]              anode_common,
  output logic [2:0]              led_status
);

  localparam longint unsigned MAX_GATE = longint'(GATE_CYCLES) << (2**GATE_SHIFT_W - 1);
  localparam int GATE_W = $clog2(MAX_GATE);

  state_t              state, next_state;
  logic [GATE_W-1:0]   gate_cnt;
  logic                ss_q;
  logic                gate_open, latch_now;
  logic [CNT_W-1:0]    cnt [NUM_CH];
  logic [NUM_CH-1:0]   sat;
  logic [CNT_W-1:0]    result [NUM_CH];
  logic [20:0]         stretch_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (enable) next_state = ST_GATE;
      ST_GATE:  if (gate_cnt == '0) next_state = ST_LATCH;
      ST_LATCH: next_state = (enable && !ss_q) ? ST_GATE : ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    gate_open = (state == ST_GATE);
    latch_now = (state == ST_LATCH);
  end

  assign busy = gate_open;

  // Gate length and mode are captured only on entry to GATE.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      ss_q     <= 1'b1;
    end else if (next_state == ST_GATE && state != ST_GATE) begin
      gate_cnt <= (GATE_W'(GATE_CYCLES) << gate_sel) - GATE_W'(1);
      ss_q     <= single_shot;
    end else if (gate_open && gate_cnt != '0) begin
      gate_cnt <= gate_cnt - GATE_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    freq_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .freq_in  (freq_in[g]),
      .count_en (gate_open),
      .clr      (latch_now),
      .count    (cnt[g]),
      .sat      (sat[g])
    );
  end

  // NOTE: the result array is a handful of flops rather than a RAM, so it is
  // reset explicitly and count_out reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
      overflow    <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= latch_now;
      if (latch_now) begin
        for (int i = 0; i < NUM_CH; i++) result[i] <= cnt[i];
        overflow <= sat;
      end
    end
  end

  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (SEL_W'(i) == ch_sel) count_out = result[i];
  end

  always_ff @(posedge clk) begin
    if (rst)                  stretch_q <= '0;
    else if (count_valid)     stretch_q <= 21'h100000;
    else if (stretch_q != '0) stretch_q <= stretch_q - 21'd1;
  end

  assign led_status = {|overflow, count_valid | (stretch_q != '0), gate_open};

`ifdef FREQ_COUNTER_SEG_EN
  localparam int DD_BITS = (CNT_W < DD_MAX_BITS) ? CNT_W : DD_MAX_BITS;

  logic [DD_BITS-1:0]      dd_bin;
  logic [23:0]             dd_bcd, dd_adj, disp_bcd;
  logic [4:0]              dd_left;
  logic                    sel_ovf, ovf_pend, disp_ovf, disp_on;
  logic [SCAN_W-1:0]       scan_div;
  logic [2:0]              digit_idx;
  logic [3:0]              cur_digit;
  logic                    lead_blank;

  always_comb begin
    sel_ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (SEL_W'(i) == ch_sel) sel_ovf = overflow[i];
  end

  assign dd_adj = bcd_adjust(dd_bcd);

  // One binary bit shifted into the BCD register per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dd_bin   <= '0;
      dd_bcd   <= '0;
      dd_left  <= '0;
      disp_bcd <= '0;
      ovf_pend <= 1'b0;
      disp_ovf <= 1'b0;
      disp_on  <= 1'b0;
    end else if (count_valid) begin
      dd_bin   <= count_out[DD_BITS-1:0];
      dd_bcd   <= '0;
      dd_left  <= 5'(DD_BITS);
      ovf_pend <= sel_ovf;
    end else if (dd_left != '0) begin
      {dd_bcd, dd_bin} <= {dd_adj, dd_bin} << 1;
      dd_left          <= dd_left - 5'd1;
      if (dd_left == 5'd1) begin
        disp_bcd <= {dd_adj[22:0], dd_bin[DD_BITS-1]};
        disp_ovf <= ovf_pend;
        disp_on  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_div  <= '0;
      digit_idx <= '0;
    end else begin
      scan_div <= scan_div + 1'b1;
      if (&scan_div) digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end
  end

  always_comb begin
    cur_digit  = disp_bcd[digit_idx*4 +: 4];
    lead_blank = (digit_idx != 3'd0) && ((disp_bcd >> {digit_idx, 2'b00}) == 24'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      segment_output <= SEG_BLANK;
      anode_common   <= 6'h3F;
    end else begin
      anode_common <= ~(6'd1 << digit_idx);
      if (!disp_on || (lead_blank && !disp_ovf)) segment_output <= SEG_BLANK;
      else if (disp_ovf)                         segment_output <= SEG_DASH;
      else                                       segment_output <= seg_decode(cur_digit);
    end
  end
`else
  assign segment_output = 7'h7F;
  assign anode_common   = 6'h3F;
`endif

endmodule

// File: tb/tb_freq_counter_mc.sv
// Directed bench for freq_counter_mc at NUM_CH=2, CNT_W=8, GATE_CYCLES=100.
module tb_freq_counter_mc;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;
  localparam int GATE   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] freq_in;
  logic              enable;
  logic              single_shot;
  logic [1:0]        gate_sel;
  logic [0:0]        ch_sel;
  logic [CNT_W-1:0]  count_out;
  logic              count_valid;
  logic [NUM_CH-1:0] overflow;
  logic              busy;
  logic [6:0]        segment_output;
  logic [5:0]        anode_common;
  logic [2:0]        led_status;

  freq_counter_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .GATE_CYCLES(GATE)) dut (
    .clk            (clk),
    .rst            (rst),
    .freq_in        (freq_in),
    .enable         (enable),
    .single_shot    (single_shot),
    .gate_sel       (gate_sel),
    .ch_sel         (ch_sel),
    .count_out      (count_out),
    .count_valid    (count_valid),
    .overflow       (overflow),
    .busy           (busy),
    .segment_output (segment_output),
    .anode_common   (anode_common),
    .led_status     (led_status)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass  = 0;
  int n_total = 0;

  // Periodic pulse source: one-cycle high pulse every per[ch] cycles.
  int per [NUM_CH];
  bit gen_on = 1'b0;

  initial forever begin
    @(negedge clk);
    if (gen_on)
      for (int c = 0; c < NUM_CH; c++)
        freq_in[c] = (per[c] != 0) && ((cyc % per[c]) == 0);
  end

  typedef struct {
    int         p0;
    int         p1;
    logic [1:0] gs;
    int         exp0;
    int         exp1;
    logic [1:0] exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic read_ch(input logic [0:0] ch, output logic [CNT_W-1:0] v);
    ch_sel = ch;
    #1 v = count_out;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (count_valid) got = 1'b1;
    end
  endtask

  // Single-shot gate; gate_sel is scrambled right after the start to show it is ignored.
  task automatic run_gate(input logic [1:0] gs, output int busy_len, output bit got);
    @(negedge clk);
    gate_sel = gs; single_shot = 1'b1; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; gate_sel = ~gs;
    busy_len = 0;
    while (busy && busy_len < 2000) begin
      busy_len++;
      @(negedge clk);
    end
    wait_valid(4, got);
  endtask

  // Gate with freq_in[0] driven from pat: pat[m] is the pin level m cycles into the gate.
  task automatic manual_gate(input logic [127:0] pat, output bit got);
    gen_on = 1'b0; freq_in = '0;
    repeat (4) @(negedge clk);
    gate_sel = 2'd0; single_shot = 1'b1; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    got = 1'b0;
    for (int m = 0; m < 112; m++) begin
      freq_in[0] = pat[m];
      @(negedge clk);
      if (count_valid) got = 1'b1;
    end
    freq_in = '0;
  endtask

  vec_t             vecs [6];
  int               blen;
  bit               got, saw;
  logic [CNT_W-1:0] v;
  int unsigned      stamp [3];
  logic [127:0]     pat;

  initial begin
    vecs[0] = '{10,  4, 2'd0,  10, 25, 2'b00};
    vecs[1] = '{ 2,  0, 2'd3, 255,  0, 2'b01};
    vecs[2] = '{ 0,  0, 2'd0,   0,  0, 2'b00};
    vecs[3] = '{ 5,  5, 2'd1,  40, 40, 2'b00};
    vecs[4] = '{20, 50, 2'd2,  20,  8, 2'b00};
    vecs[5] = '{ 0,  2, 2'd0,   0, 50, 2'b00};

    rst = 1'b1; freq_in = '0; enable = 1'b0; single_shot = 1'b1;
    gate_sel = 2'd0; ch_sel = 1'b0;
    per[0] = 0; per[1] = 0;
    repeat (3) @(negedge clk);
    check("reset count_out", count_out, 0);
    check("reset count_valid", count_valid, 0);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    check("reset led_status", led_status, 0);
    check("reset segment_output", segment_output, 7'h7F);
    check("reset anode_common", anode_common, 6'h3F);
    rst = 1'b0;

    // First gate starts on the first cycle enable is sampled after reset.
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check("gate starts after reset", busy, 1);
    wait_valid(GATE + 10, got);
    check("first gate valid", got, 1);

    foreach (vecs[i]) begin
      per[0] = vecs[i].p0; per[1] = vecs[i].p1; gen_on = 1'b1;
      repeat (12) @(negedge clk);
      run_gate(vecs[i].gs, blen, got);
      check($sformatf("v%0d gate length", i), blen, GATE << vecs[i].gs);
      check($sformatf("v%0d count_valid", i), got, 1);
      check($sformatf("v%0d led_status", i), led_status, {|vecs[i].exp_ovf, 2'b10});
      read_ch(1'b0, v);
      check($sformatf("v%0d ch0", i), v, vecs[i].exp0);
      read_ch(1'b1, v);
      check($sformatf("v%0d ch1", i), v, vecs[i].exp1);
      check($sformatf("v%0d overflow", i), overflow, vecs[i].exp_ovf);
      @(negedge clk);
      check($sformatf("v%0d valid one cycle", i), count_valid, 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d back to idle", i), busy, 0);
    end

    // Continuous mode: three back-to-back gates, then enable drops mid-gate.
    per[0] = 5; per[1] = 5; gen_on = 1'b1;
    repeat (12) @(negedge clk);
    single_shot = 1'b0; gate_sel = 2'd0; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid(300, got);
      stamp[k] = cyc;
      check($sformatf("cont%0d valid", k), got, 1);
      read_ch(1'b0, v);
      check($sformatf("cont%0d ch0", k), v, 20);
      read_ch(1'b1, v);
      check($sformatf("cont%0d ch1", k), v, 20);
    end
    check("cont interval 1", stamp[1] - stamp[0], GATE + 1);
    check("cont interval 2", stamp[2] - stamp[1], GATE + 1);
    enable = 1'b0; single_shot = 1'b1;
    check("enable drop keeps gate open", busy, 1);
    wait_valid(300, got);
    check("final gate completes", got, 1);
    read_ch(1'b0, v);
    check("final gate ch0", v, 20);
    repeat (3) @(negedge clk);
    check("idle after enable drop", busy, 0);

    // Edge on the last GATE cycle is counted.
    pat = '0;
    for (int m = 97; m < 102; m++) pat[m] = 1'b1;
    manual_gate(pat, got);
    check("last-cycle probe valid", got, 1);
    read_ch(1'b0, v);
    check("last-cycle edge counted", v, 1);

    // One edge inside the gate, a second one landing in LATCH.
    pat = '0;
    pat[95] = 1'b1;
    for (int m = 98; m < 102; m++) pat[m] = 1'b1;
    manual_gate(pat, got);
    check("latch probe valid", got, 1);
    read_ch(1'b0, v);
    check("latch edge discarded", v, 1);

    // Reset in the middle of a gate.
    per[0] = 10; per[1] = 0; gen_on = 1'b1;
    repeat (12) @(negedge clk);
    gate_sel = 2'd0; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (49) @(negedge clk);
    check("mid gate busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    read_ch(1'b0, v);
    check("rst mid gate count_out", v, 0);
    check("rst mid gate busy", busy, 0);
    check("rst mid gate led_status", led_status, 0);
    check("rst mid gate overflow", overflow, 0);
    check("rst mid gate segment_output", segment_output, 7'h7F);
    check("rst mid gate anode_common", anode_common, 6'h3F);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (count_valid) saw = 1'b1;
    end
    check("no valid after reset", saw, 0);
    run_gate(2'd0, blen, got);
    check("post-reset gate valid", got, 1);
    read_ch(1'b0, v);
    check("post-reset gate ch0", v, 10);

`ifdef FREQ_COUNTER_SEG_EN
    // Fresh reset aligns the digit scan so digit 0 is active first.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pat = '0;
    for (int k = 0; k < 42; k++) pat[5 + 2*k] = 1'b1;
    ch_sel = 1'b0;
    manual_gate(pat, got);
    check("display gate valid", got, 1);
    read_ch(1'b0, v);
    check("display gate ch0", v, 42);
    repeat (5) @(negedge clk);
    check("digit0 anode", anode_common, 6'b111110);
    check("digit0 shows 2", segment_output, 7'h24);
    saw = 1'b0;
    for (int i = 0; i < 70000 && !saw; i++) begin
      @(negedge clk);
      if (anode_common == 6'b111101) saw = 1'b1;
    end
    check("digit1 reached", saw, 1);
    check("digit1 shows 4", segment_output, 7'h19);
`else
    check("display off segment_output", segment_output, 7'h7F);
    check("display off anode_common", anode_common, 6'h3F);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
